// File: rtl/mem_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_scheduler
// Purpose  : Round-robin arbiter that serialises PE/SE accesses to the shared
//            snapshot/weight memory and returns one tagged response each.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_scheduler #(
    parameter int N_REQ  = 4,
    parameter int T_W    = 4,
    parameter int X_W    = 5,
    parameter int Y_W    = 5,
    parameter int DATA_W = 32,
    parameter int ID_W   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_wr,
    input  logic [N_REQ*T_W-1:0]    req_t,
    input  logic [N_REQ*X_W-1:0]    req_x,
    input  logic [N_REQ*Y_W-1:0]    req_y,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic                    mem_cmd_valid,
    input  logic                    mem_cmd_ready,
    output logic                    mem_cmd_wr,
    output logic [T_W-1:0]          mem_t,
    output logic [X_W-1:0]          mem_x,
    output logic [Y_W-1:0]          mem_y,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_rvalid,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    rsp_wr,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy,
    output logic                    err_spurious
);

    localparam logic [1:0] c_st_idle    = 2'd0;
    localparam logic [1:0] c_st_cmd     = 2'd1;
    localparam logic [1:0] c_st_wait_rd = 2'd2;
    localparam logic [1:0] c_st_resp    = 2'd3;

    localparam logic [ID_W-1:0] c_rr_init = ID_W'(N_REQ - 1);

    logic [1:0]        r_state;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ID_W-1:0]   r_id;
    logic              r_wr;
    logic [T_W-1:0]    r_t;
    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_found;
    logic [ID_W-1:0]   w_winner;
    logic              w_grant;

    // Scan from farthest to nearest so the nearest candidate after rr_ptr wins.
    always_comb begin
        int w_idx;
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = (int'(r_rr_ptr) + k) % N_REQ;
            if (req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = ID_W'(w_idx);
            end
        end
    end

    // Reset gates the combinational grant so req_ready is 0 while reset is held.
    assign w_grant = (r_state == c_st_idle) && w_found && !reset;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_st_idle;
            r_rr_ptr <= c_rr_init;
            r_id     <= '0;
            r_wr     <= 1'b0;
            r_t      <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (mem_rvalid && (r_state != c_st_wait_rd)) begin
                r_err <= 1'b1;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_found) begin
                        r_id     <= w_winner;
                        r_wr     <= req_wr[w_winner];
                        r_t      <= req_t[w_winner*T_W +: T_W];
                        r_x      <= req_x[w_winner*X_W +: X_W];
                        r_y      <= req_y[w_winner*Y_W +: Y_W];
                        r_wdata  <= req_wdata[w_winner*DATA_W +: DATA_W];
                        r_rr_ptr <= w_winner;
                        r_state  <= c_st_cmd;
                    end
                end
                c_st_cmd: begin
                    if (mem_cmd_ready) begin
                        if (r_wr) begin
                            r_rdata <= '0;
                            r_state <= c_st_resp;
                        end else begin
                            r_state <= c_st_wait_rd;
                        end
                    end
                end
                c_st_wait_rd: begin
                    if (mem_rvalid) begin
                        r_rdata <= mem_rdata;
                        r_state <= c_st_resp;
                    end
                end
                c_st_resp: begin
                    if (rsp_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign mem_cmd_valid = (r_state == c_st_cmd);
    assign mem_cmd_wr    = r_wr;
    assign mem_t         = r_t;
    assign mem_x         = r_x;
    assign mem_y         = r_y;
    assign mem_wdata     = r_wdata;

    assign rsp_valid     = (r_state == c_st_resp);
    assign rsp_id        = r_id;
    assign rsp_wr        = r_wr;
    assign rsp_data      = r_rdata;

    assign busy          = (r_state != c_st_idle);
    assign err_spurious  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_scheduler
// Purpose  : Self-checking bench: directed vectors, corner sequences and a
//            randomized run against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_scheduler;

    localparam int N_REQ  = 4;
    localparam int T_W    = 4;
    localparam int X_W    = 5;
    localparam int Y_W    = 5;
    localparam int DATA_W = 32;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ-1:0]        req_wr;
    logic [N_REQ*T_W-1:0]    req_t;
    logic [N_REQ*X_W-1:0]    req_x;
    logic [N_REQ*Y_W-1:0]    req_y;
    logic [N_REQ*DATA_W-1:0] req_wdata;
    logic                    mem_cmd_valid;
    logic                    mem_cmd_ready;
    logic                    mem_cmd_wr;
    logic [T_W-1:0]          mem_t;
    logic [X_W-1:0]          mem_x;
    logic [Y_W-1:0]          mem_y;
    logic [DATA_W-1:0]       mem_wdata;
    logic                    mem_rvalid;
    logic [DATA_W-1:0]       mem_rdata;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_wr;
    logic [DATA_W-1:0]       rsp_data;
    logic                    busy;
    logic                    err_spurious;

    mem_access_scheduler #(
        .N_REQ(N_REQ), .T_W(T_W), .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W), .ID_W(ID_W)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_t(req_t), .req_x(req_x), .req_y(req_y), .req_wdata(req_wdata),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_wr(mem_cmd_wr),
        .mem_t(mem_t), .mem_x(mem_x), .mem_y(mem_y), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_wr(rsp_wr),
        .rsp_data(rsp_data), .busy(busy), .err_spurious(err_spurious)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
    endtask

    // Inputs change right after the falling edge; outputs are sampled 2ns later.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req_valid = '0; req_wr = '0; req_t = '0; req_x = '0; req_y = '0; req_wdata = '0;
        mem_cmd_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
    endtask

    task automatic load_req(input int id, input logic wr, input logic [T_W-1:0] t,
                            input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                            input logic [DATA_W-1:0] wd);
        req_valid[id] = 1'b1;
        req_wr[id]    = wr;
        req_t[id*T_W +: T_W]          = t;
        req_x[id*X_W +: X_W]          = x;
        req_y[id*Y_W +: Y_W]          = y;
        req_wdata[id*DATA_W +: DATA_W] = wd;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference arbitration: first valid requester after the last winner, cyclically.
    function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] v);
        for (int k = 1; k <= N_REQ; k++) begin
            if (v[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    logic [DATA_W-1:0] mem_model [logic [13:0]];

    function automatic logic [DATA_W-1:0] mlook(input logic [T_W-1:0] t, input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
        logic [13:0] key;
        key = {t, x, y};
        return mem_model.exists(key) ? mem_model[key] : '0;
    endfunction

    typedef struct {
        int                id;
        logic              wr;
        logic [T_W-1:0]    t;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] rdata;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    // Randomized-phase state
    bit                p_valid [N_REQ];
    logic              p_wr    [N_REQ];
    logic [T_W-1:0]    p_t     [N_REQ];
    logic [X_W-1:0]    p_x     [N_REQ];
    logic [Y_W-1:0]    p_y     [N_REQ];
    logic [DATA_W-1:0] p_wdata [N_REQ];
    int                p_wait  [N_REQ];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int gid[$];
        int gcyc[$];
        int rid[$];
        int exp_order [5];
        logic rv_next;
        bit outst, cmd_done, resp_due;
        int o_id, m_rr, rd_cnt, n_rsp;
        logic o_wr;
        logic [T_W-1:0] o_t;
        logic [X_W-1:0] o_x;
        logic [Y_W-1:0] o_y;
        logic [DATA_W-1:0] o_wdata, o_exp;

        vecs[0] = '{id:2, wr:1'b1, t:4'd3,  x:5'd7,  y:5'd9,  wdata:32'hDEADBEEF, rdata:32'h0,        exp_data:32'h0};
        vecs[1] = '{id:0, wr:1'b0, t:4'd1,  x:5'd2,  y:5'd4,  wdata:32'h0,        rdata:32'hA5A5A5A5, exp_data:32'hA5A5A5A5};
        vecs[2] = '{id:3, wr:1'b0, t:4'd15, x:5'd31, y:5'd31, wdata:32'h0,        rdata:32'hFFFFFFFF, exp_data:32'hFFFFFFFF};
        vecs[3] = '{id:1, wr:1'b1, t:4'd0,  x:5'd0,  y:5'd0,  wdata:32'h13579BDF, rdata:32'h0,        exp_data:32'h0};
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state, with requests already pending
        reset = 1'b1;
        clear_inputs();
        req_valid = '1;
        tick();
        #2;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_cmd_valid", mem_cmd_valid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_spurious, 0);
        chk("rst_fields", {mem_t, mem_x, mem_y, mem_wdata, rsp_id, rsp_wr, mem_cmd_wr}, 0);
        chk("rst_rsp_data", rsp_data, 0);
        do_reset();

        // Table-driven single transactions
        for (int v = 0; v < 4; v++) begin
            tick();
            clear_inputs();
            mem_cmd_ready = 1'b1;
            rsp_ready     = 1'b1;
            load_req(vecs[v].id, vecs[v].wr, vecs[v].t, vecs[v].x, vecs[v].y, vecs[v].wdata);
            #2;
            chk("vec_grant", req_ready, 64'(1) << vecs[v].id);
            tick();
            req_valid = '0;
            #2;
            chk("vec_cmd_valid", mem_cmd_valid, 1);
            chk("vec_cmd_fields", {mem_cmd_wr, mem_t, mem_x, mem_y},
                {vecs[v].wr, vecs[v].t, vecs[v].x, vecs[v].y});
            if (vecs[v].wr) chk("vec_cmd_wdata", mem_wdata, vecs[v].wdata);
            tick();
            if (!vecs[v].wr) begin
                mem_rvalid = 1'b1;
                mem_rdata  = vecs[v].rdata;
                #2;
                chk("vec_rd_wait", {rsp_valid, mem_cmd_valid, busy}, 3'b001);
                tick();
                mem_rvalid = 1'b0;
            end
            #2;
            chk("vec_rsp_valid", rsp_valid, 1);
            chk("vec_rsp_fields", {rsp_id, rsp_wr}, {2'(vecs[v].id), vecs[v].wr});
            chk("vec_rsp_data", rsp_data, vecs[v].exp_data);
            tick();
            #2;
            chk("vec_idle", {busy, rsp_valid}, 0);
        end

        // Round-robin with all four requesters reading continuously
        do_reset();
        rv_next = 1'b0;
        for (int c = 0; c < 40 && gid.size() < 5; c++) begin
            tick();
            req_valid = '1; req_wr = '0; mem_cmd_ready = 1'b1; rsp_ready = 1'b1;
            mem_rvalid = rv_next;
            mem_rdata  = 32'(c);
            #2;
            for (int i = 0; i < N_REQ; i++) begin
                if (req_ready[i]) begin
                    gid.push_back(i);
                    gcyc.push_back(c);
                end
            end
            if (rsp_valid && rsp_ready) rid.push_back(int'(rsp_id));
            rv_next = mem_cmd_valid && mem_cmd_ready && !mem_cmd_wr;
        end
        chk("rr_grant_count", gid.size(), 5);
        for (int i = 0; i < gid.size(); i++) chk("rr_grant_order", gid[i], exp_order[i]);
        for (int i = 1; i < gcyc.size(); i++) chk("rr_period", gcyc[i] - gcyc[i-1], 4);
        chk("rr_rsp_count", rid.size() >= 4, 1);
        for (int i = 0; i < rid.size() && i < 4; i++) chk("rr_rsp_order", rid[i], exp_order[i]);

        // Read with command stall
        do_reset();
        tick();
        load_req(1, 1'b0, 4'd5, 5'd3, 5'd12, 32'h0);
        rsp_ready = 1'b1;
        #2;
        chk("stall_grant", req_ready, 4'b0010);
        for (int s = 0; s < 3; s++) begin
            tick();
            req_valid = '0;
            mem_cmd_ready = 1'b0;
            #2;
            chk("stall_cmd", {mem_cmd_valid, mem_cmd_wr, mem_t, mem_x, mem_y, busy},
                {1'b1, 1'b0, 4'd5, 5'd3, 5'd12, 1'b1});
        end
        tick();
        mem_cmd_ready = 1'b1;
        #2;
        chk("stall_cmd_hs", {mem_cmd_valid, busy}, 2'b11);
        tick();
        mem_cmd_ready = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        #2;
        chk("stall_wait", {rsp_valid, busy}, 2'b01);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk("stall_rsp", {rsp_valid, rsp_id, rsp_wr, busy}, {1'b1, 2'd1, 1'b0, 1'b1});
        chk("stall_rsp_data", rsp_data, 32'h12345678);
        tick();
        #2;
        chk("stall_idle", busy, 0);

        // Response backpressure with requester 0 still requesting
        tick();
        clear_inputs();
        load_req(0, 1'b1, 4'd1, 5'd2, 5'd3, 32'hCAFE0001);
        mem_cmd_ready = 1'b1;
        #2;
        chk("bp_grant", req_ready, 4'b0001);
        tick();
        #2;
        chk("bp_cmd", {mem_cmd_valid, req_ready}, 5'b10000);
        for (int s = 0; s < 5; s++) begin
            tick();
            #2;
            chk("bp_hold", {rsp_valid, rsp_id, rsp_wr, req_ready}, {1'b1, 2'd0, 1'b1, 4'b0000});
            chk("bp_hold_data", rsp_data, 0);
        end
        tick();
        rsp_ready = 1'b1;
        #2;
        chk("bp_hs_cycle", {rsp_valid, req_ready}, 5'b10000);
        tick();
        #2;
        chk("bp_regrant", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        tick();
        tick();
        #2;
        chk("bp_idle", {busy, rsp_valid}, 0);

        // Randomized traffic against a transaction-level model
        do_reset();
        outst = 0; cmd_done = 0; resp_due = 0; rd_cnt = 0; n_rsp = 0; m_rr = N_REQ - 1;
        o_id = 0; o_wr = 0; o_t = '0; o_x = '0; o_y = '0; o_wdata = '0; o_exp = '0;
        for (int i = 0; i < N_REQ; i++) begin
            p_valid[i] = 0; p_wait[i] = 0; p_wr[i] = 0;
            p_t[i] = '0; p_x[i] = '0; p_y[i] = '0; p_wdata[i] = '0;
        end
        for (int c = 0; c < 2600; c++) begin
            bit outst0;
            int w;
            logic [N_REQ-1:0] vv, er;
            tick();
            if (c < 2300) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!p_valid[i] && $urandom_range(0, 2) == 0) begin
                        p_valid[i] = 1;
                        p_wr[i]    = 1'($urandom_range(0, 1));
                        p_t[i]     = 4'($urandom_range(0, 1));
                        p_x[i]     = 5'($urandom_range(0, 2));
                        p_y[i]     = 5'($urandom_range(0, 1));
                        p_wdata[i] = $urandom;
                        p_wait[i]  = 0;
                    end
                end
            end
            for (int i = 0; i < N_REQ; i++) begin
                req_valid[i] = p_valid[i];
                req_wr[i]    = p_wr[i];
                req_t[i*T_W +: T_W]           = p_t[i];
                req_x[i*X_W +: X_W]           = p_x[i];
                req_y[i*Y_W +: Y_W]           = p_y[i];
                req_wdata[i*DATA_W +: DATA_W] = p_wdata[i];
                vv[i] = p_valid[i];
            end
            mem_cmd_ready = ($urandom_range(0, 2) != 0);
            rsp_ready     = ($urandom_range(0, 2) != 0);
            mem_rvalid    = 1'b0;
            mem_rdata     = $urandom;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mlook(o_t, o_x, o_y);
                end
            end
            #2;
            outst0 = outst;
            chk("rand_busy", busy, outst0);
            chk("rand_rsp_valid", rsp_valid, resp_due);
            if (rsp_valid && resp_due) begin
                chk("rand_rsp_fields", {rsp_id, rsp_wr}, {2'(o_id), o_wr});
                chk("rand_rsp_data", rsp_data, o_exp);
                if (rsp_ready) begin
                    outst = 0; resp_due = 0; n_rsp++;
                end
            end
            if (mem_rvalid) resp_due = 1;
            chk("rand_cmd_valid", mem_cmd_valid, outst0 && !cmd_done);
            if (mem_cmd_valid && outst0 && !cmd_done) begin
                chk("rand_cmd_fields", {mem_cmd_wr, mem_t, mem_x, mem_y}, {o_wr, o_t, o_x, o_y});
                if (o_wr) chk("rand_cmd_wdata", mem_wdata, o_wdata);
                if (mem_cmd_ready) begin
                    cmd_done = 1;
                    if (o_wr) begin
                        mem_model[{o_t, o_x, o_y}] = o_wdata;
                        resp_due = 1;
                    end else begin
                        rd_cnt = $urandom_range(1, 3);
                    end
                end
            end
            w  = outst0 ? -1 : rr_pick(m_rr, vv);
            er = '0;
            if (w >= 0) er[w] = 1'b1;
            chk("rand_req_ready", req_ready, er);
            if (w >= 0) begin
                chk("rand_fairness", p_wait[w] <= N_REQ - 1, 1);
                for (int j = 0; j < N_REQ; j++) if (j != w && p_valid[j]) p_wait[j]++;
                outst = 1; cmd_done = 0; resp_due = 0;
                o_id = w; o_wr = p_wr[w]; o_t = p_t[w]; o_x = p_x[w]; o_y = p_y[w];
                o_wdata = p_wdata[w];
                o_exp = p_wr[w] ? '0 : mlook(p_t[w], p_x[w], p_y[w]);
                m_rr = w;
                p_valid[w] = 0;
            end
        end
        begin
            bit any_pend;
            any_pend = 0;
            for (int i = 0; i < N_REQ; i++) any_pend |= p_valid[i];
            chk("rand_drained", {outst, any_pend}, 0);
        end
        chk("rand_rsp_count", n_rsp > 50, 1);
        chk("rand_no_err", err_spurious, 0);

        // Spurious read data while idle
        tick();
        clear_inputs();
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBAD0BAD0;
        #2;
        chk("spur_before", err_spurious, 0);
        tick();
        mem_rvalid = 1'b0;
        #2;
        chk("spur_set", {err_spurious, rsp_valid, busy}, 3'b100);
        tick();
        tick();
        #2;
        chk("spur_sticky", {err_spurious, rsp_valid}, 2'b10);

        // Asynchronous reset during WAIT_RD
        tick();
        load_req(2, 1'b0, 4'd9, 5'd9, 5'd9, 32'h0);
        mem_cmd_ready = 1'b1;
        rsp_ready     = 1'b1;
        #2;
        chk("arst_grant", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        tick();
        mem_cmd_ready = 1'b0;
        #2;
        chk("arst_waiting", {busy, rsp_valid, mem_cmd_valid}, 3'b100);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_ctrl", {busy, rsp_valid, mem_cmd_valid, err_spurious, req_ready}, 0);
        chk("arst_fields", {mem_t, mem_x, mem_y, mem_cmd_wr, rsp_id, rsp_wr}, 0);
        tick();
        tick();
        reset = 1'b0;
        req_valid = '1;
        #2;
        chk("arst_next_grant", req_ready, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_access_scheduler.md
Name: mem_access_scheduler

Overview:
- Clocked round-robin scheduler that shares the single snapshot/weight memory (T, x, y addressed) between the NOC-side requesters: PEs 1..3 and the SE.
- Accepts one request at a time and sequences the memory command. For reads it waits for read data; every transaction returns one tagged response.
- Sits between the NOC interface logic and the memory; it replaces ad-hoc direct access by the memory wrapper.

Parameters:
- N_REQ, 4, number of requesters (index 0..2 = PE1..PE3, 3 = SE).
- T_W, 4, timestep index width.
- X_W, 5, x coordinate width.
- Y_W, 5, y coordinate width.
- DATA_W, 32, data word width.
- ID_W, 2, requester id width; must satisfy 2**ID_W >= N_REQ.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester accept, one-hot or zero.
- req_wr  in  N_REQ  per-requester op (1 = write, 0 = read).
- req_t  in  N_REQ*T_W  packed timestep per requester (requester i at [i*T_W +: T_W]).
- req_x  in  N_REQ*X_W  packed x coordinate.
- req_y  in  N_REQ*Y_W  packed y coordinate.
- req_wdata  in  N_REQ*DATA_W  packed write data.
- mem_cmd_valid  out  1  memory command valid.
- mem_cmd_ready  in  1  memory accepts command.
- mem_cmd_wr  out  1  command op.
- mem_t  out  T_W  command timestep.
- mem_x  out  X_W  command x.
- mem_y  out  Y_W  command y.
- mem_wdata  out  DATA_W  command write data.
- mem_rvalid  in  1  read data valid, single-cycle pulse.
- mem_rdata  in  DATA_W  read data.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  requester index of the response.
- rsp_wr  out  1  op echoed back.
- rsp_data  out  DATA_W  read data; 0 for writes.
- busy  out  1  high whenever state != IDLE.
- err_spurious  out  1  sticky flag: mem_rvalid seen outside WAIT_RD.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE;
  - all outputs 0, including req_ready, mem_cmd_valid, rsp_valid, err_spurious and the latched fields;
  - rr_ptr = N_REQ-1, so requester 0 has first priority.
- Reset mid-transaction abandons it. No response is issued. The memory is expected to be reset together with this block.
- FSM states: IDLE, CMD, WAIT_RD, RESP.
- IDLE:
  - Winner = first i with req_valid[i] = 1, searching rr_ptr+1, rr_ptr+2, ... modulo N_REQ.
  - req_ready[winner] is asserted combinationally in the same cycle (handshake = valid & ready).
  - At that edge: latch op/t/x/y/wdata/id, set rr_ptr = winner, go to CMD.
  - No req_valid: stay in IDLE, req_ready = 0.
  - req_ready is 0 in every other state.
- CMD:
  - mem_cmd_valid = 1; fields are driven from registers and held stable until mem_cmd_ready.
  - On the handshake edge: a write goes to RESP with rsp_data = 0; a read goes to WAIT_RD.
- WAIT_RD:
  - On mem_rvalid, latch mem_rdata and go to RESP.
  - No timeout; waits indefinitely.
- RESP:
  - rsp_valid = 1 with rsp_id/rsp_wr/rsp_data held stable until rsp_ready.
  - On the handshake edge go to IDLE.
  - A new grant can occur in the cycle after that edge, never in the same cycle.
- Latency (request handshake at cycle 0):
  - mem_cmd_valid at cycle 1.
  - Write with mem_cmd_ready = 1: rsp_valid at cycle 2.
  - Read with rvalid one cycle after the command handshake: rsp_valid at cycle 3.
  - Minimum transaction period: 3 cycles for a write, 4 for a read.
- mem_rvalid in IDLE/CMD/RESP, including the same cycle as the command handshake: data ignored, err_spurious set to 1 and held until reset.
- Fairness: a requester that keeps req_valid high is granted within N_REQ grants.
- Requesters must hold valid and fields stable until req_ready. A requester that drops req_valid before a grant is simply skipped.
- rr_ptr wraps from N_REQ-1 to 0.
- Exactly one transaction is outstanding at any time.

Test Plan:
- Reset, then req_valid = 4'b1111 held with rsp_ready = 1, mem_cmd_ready = 1, reads with rvalid one cycle later -> grant order 0, 1, 2, 3, 0; rsp_id follows the same order; 4 cycles per transaction.
- Single write from requester 2 (t = 3, x = 7, y = 9, wdata = 32'hDEADBEEF) -> mem_cmd_valid at cycle 1 with those fields; rsp_valid at cycle 2 with id = 2, wr = 1, data = 0.
- Read from requester 1 with mem_cmd_ready stalled 3 cycles and rdata = 32'h12345678 -> command fields stable throughout the stall; rsp_data = 32'h12345678; busy high throughout.
- rsp_ready held low 5 cycles while requester 0 is valid -> rsp fields stable; req_ready[0] = 0 until the cycle after the response handshake.
- mem_rvalid pulse while in IDLE -> err_spurious = 1 sticky; no rsp_valid.
- Assert reset during WAIT_RD -> all outputs 0 immediately (async); after release, the next grant goes to requester 0.
